// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: one shared period counter, per-channel duty set by
// edge-detected inc/dec buttons, duty shadowed to period boundaries, optional phase stagger.
module pwm_multi_channel #(
   parameter int CHANNELS  = 3,
   parameter int CNT_W     = 8,
   parameter int PERIOD    = 100,
   parameter int STEP      = 5,
   parameter int DUTY_INIT = 30,
   parameter int DUTY_MIN  = 0,
   parameter int DUTY_MAX  = PERIOD,
   parameter int ALIGN     = 0,
   parameter int SEL_W     = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inc,
   input  logic                dec,
   input  logic [SEL_W-1:0]    sel,
   output logic [CHANNELS-1:0] out,
   output logic [CNT_W-1:0]    duty_o,
   output logic                pstart
);
   localparam int EW = CNT_W + 1;
   localparam logic [EW-1:0]    PERIOD_E = EW'(PERIOD);
   localparam logic [EW-1:0]    STEP_E   = EW'(STEP);
   localparam logic [EW-1:0]    MIN_E    = EW'(DUTY_MIN);
   localparam logic [EW-1:0]    MAX_E    = EW'(DUTY_MAX);
   localparam logic [CNT_W-1:0] STEP_D   = CNT_W'(STEP);
   localparam logic [CNT_W-1:0] MIN_D    = CNT_W'(DUTY_MIN);
   localparam logic [CNT_W-1:0] INIT_D   = CNT_W'(DUTY_INIT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0]    cnt;
   logic                inc_q;
   logic                dec_q;
   logic                inc_ev;
   logic                dec_ev;
   logic                wrap;
   logic [CNT_W-1:0]    target     [CHANNELS];
   logic [CNT_W-1:0]    active     [CHANNELS];
   logic [CNT_W-1:0]    target_nxt [CHANNELS];
   logic [EW-1:0]       up_sat     [CHANNELS];
   logic [CNT_W-1:0]    dn_sat     [CHANNELS];
   logic [EW-1:0]       ph         [CHANNELS];
   logic [CHANNELS-1:0] out_nxt;

   // Phase offset of a channel; staggering spreads switching edges across the period.
   function automatic logic [EW-1:0] phase_off(input int ch);
      if (ALIGN != 0) return EW'((ch * PERIOD) / CHANNELS);
      return '0;
   endfunction

   assign inc_ev = inc & ~inc_q;
   assign dec_ev = dec & ~dec_q;
   assign wrap   = (cnt == LAST_CNT);

   // Saturating duty arithmetic is done one bit wider so nothing wraps.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         up_sat[i] = {1'b0, target[i]} + STEP_E;
         if (up_sat[i] > MAX_E) up_sat[i] = MAX_E;
         if ({1'b0, target[i]} < (MIN_E + STEP_E)) dn_sat[i] = MIN_D;
         else dn_sat[i] = target[i] - STEP_D;
         target_nxt[i] = target[i];
         if (sel == SEL_W'(i)) begin
            if (inc_ev && !dec_ev) target_nxt[i] = up_sat[i][CNT_W-1:0];
            else if (dec_ev && !inc_ev) target_nxt[i] = dn_sat[i];
         end
      end
   end

   always_comb begin
      out_nxt = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         ph[i] = {1'b0, cnt} + phase_off(i);
         if (ph[i] >= PERIOD_E) ph[i] = ph[i] - PERIOD_E;
         out_nxt[i] = (ph[i] < {1'b0, active[i]});
      end
   end

   // An out-of-range sel matches no channel and reads back as zero.
   always_comb begin
      duty_o = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (sel == SEL_W'(i)) duty_o = target[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         inc_q  <= 1'b0;
         dec_q  <= 1'b0;
         out    <= '0;
         pstart <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            target[i] <= INIT_D;
            active[i] <= INIT_D;
         end
      end else begin
         cnt    <= wrap ? '0 : cnt + CNT_W'(1);
         inc_q  <= inc;
         dec_q  <= dec;
         pstart <= (cnt == '0);
         out    <= out_nxt;
         for (int i = 0; i < CHANNELS; i++) begin
            target[i] <= target_nxt[i];
            // Shadow load on the wrap edge keeps each period glitch-free.
            if (wrap) active[i] <= target[i];
         end
      end
   end

endmodule
